// File: rtl/ham_dec_pipe_pkg.sv
// Shared SEC-DED Hamming definitions: default widths, bit-map helpers and the
// decode status enum used by both the decoder and encoder-side tests.
package ham_pkg;

  localparam int HAM_DATA_BITS    = 8;
  localparam int HAM_PARITY_BITS  = $clog2(HAM_DATA_BITS) + 1;
  localparam int HAM_ENCODED_WORD = HAM_DATA_BITS + HAM_PARITY_BITS;
  localparam int HAM_CNT_W        = 16;

  typedef enum logic [1:0] {
    CLEAN = 2'd0,
    SEC   = 2'd1,
    DED   = 2'd2
  } ham_stat_e;

  function automatic logic is_pow2(input int pos);
    return (pos > 0) && ((pos & (pos - 1)) == 0);
  endfunction

  // Codeword position (1-based) of data bit idx: the idx-th non-power-of-2 position.
  function automatic int data_pos(input int idx);
    int cnt;
    int res;
    cnt = 0;
    res = 0;
    for (int p = 1; p < 256; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx && res == 0) res = p;
        cnt++;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ham_dec_pipe_syn.sv
// Combinational syndrome (XOR of set positions 1..ENCODED_WORD) and overall
// parity (XOR of every bit including the extra parity bit) of a codeword.
module ham_syn
  import ham_pkg::*;
#(
  parameter int ENCODED_WORD = HAM_ENCODED_WORD,
  parameter int PARITY_BITS  = HAM_PARITY_BITS
) (
  input  logic [ENCODED_WORD+1:1] code_i,
  output logic [PARITY_BITS-1:0]  syn_o,
  output logic                    par_o
);

  always_comb begin
    syn_o = '0;
    for (int p = 1; p <= ENCODED_WORD; p++) begin
      if (code_i[p]) syn_o = syn_o ^ PARITY_BITS'(p);
    end
    par_o = ^code_i;
  end

endmodule

// File: rtl/ham_dec_pipe.sv
// Two-stage pipelined SEC-DED Hamming decoder with valid/ready streams and
// saturating single/double error event counters.
module ham_dec_pipe
  import ham_pkg::*;
#(
  parameter int DATA_BITS    = HAM_DATA_BITS,
  parameter int PARITY_BITS  = $clog2(DATA_BITS) + 1,
  parameter int ENCODED_WORD = DATA_BITS + PARITY_BITS,
  parameter int CNT_W        = HAM_CNT_W,
  localparam int POS_W       = $clog2(ENCODED_WORD + 2)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [ENCODED_WORD+1:1] i_code,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic [DATA_BITS-1:0]    o_data,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_sec,
  output logic                    o_ded,
  output logic [POS_W-1:0]        o_err_pos,
  input  logic                    i_clr_cnt,
  output logic [CNT_W-1:0]        o_sec_cnt,
  output logic [CNT_W-1:0]        o_ded_cnt
);

  // Handshake: a beat transfers on any rising edge where valid && ready are both
  // high; valid never waits on ready, and a held beat keeps its payload stable.

  localparam logic [PARITY_BITS-1:0] MAX_SYN = PARITY_BITS'(ENCODED_WORD);

  logic [PARITY_BITS-1:0] syn;
  logic                   par;
  logic [DATA_BITS-1:0]   raw_data;

  logic                   s1_vld_q;
  logic [DATA_BITS-1:0]   s1_data_q;
  logic [PARITY_BITS-1:0] s1_syn_q;
  logic                   s1_par_q;

  logic                   out_vld_q, out_sec_q, out_ded_q;
  logic [DATA_BITS-1:0]   out_data_q, data_d;
  logic [POS_W-1:0]       out_pos_q, pos_d;
  logic [CNT_W-1:0]       sec_cnt_q, sec_cnt_d, ded_cnt_q, ded_cnt_d;

  ham_stat_e              stat_d;
  logic                   flip_en;
  logic                   s2_en;
  logic                   out_hs;

  ham_syn #(
    .ENCODED_WORD(ENCODED_WORD),
    .PARITY_BITS (PARITY_BITS)
  ) u_syn (
    .code_i(i_code),
    .syn_o (syn),
    .par_o (par)
  );

  // Only data bits are carried forward; the check bits live on in syn/par.
  for (genvar i = 0; i < DATA_BITS; i++) begin : g_data
    localparam int POS = data_pos(i);
    assign raw_data[i] = i_code[POS];
    assign data_d[i]   = s1_data_q[i] ^
                         (flip_en && (s1_syn_q == PARITY_BITS'(POS)));
  end

  assign s2_en   = !out_vld_q || i_ready;
  assign o_ready = !s1_vld_q || s2_en;
  assign out_hs  = out_vld_q && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q  <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
      s1_par_q  <= 1'b0;
    end else if (o_ready) begin
      s1_vld_q <= i_valid;
      if (i_valid) begin
        s1_data_q <= raw_data;
        s1_syn_q  <= syn;
        s1_par_q  <= par;
      end
    end
  end

  // Odd overall parity means an odd number of flips, assumed one; a zero
  // syndrome then points at the overall parity bit itself.
  always_comb begin
    stat_d  = CLEAN;
    pos_d   = '0;
    flip_en = 1'b0;
    if (s1_par_q) begin
      if (s1_syn_q == '0) begin
        stat_d = SEC;
        pos_d  = POS_W'(ENCODED_WORD + 1);
      end else if (s1_syn_q <= MAX_SYN) begin
        stat_d  = SEC;
        pos_d   = POS_W'(s1_syn_q);
        flip_en = 1'b1;
      end else begin
        stat_d = DED;
      end
    end else if (s1_syn_q != '0) begin
      stat_d = DED;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_sec_q  <= 1'b0;
      out_ded_q  <= 1'b0;
      out_pos_q  <= '0;
    end else if (s2_en) begin
      out_vld_q  <= s1_vld_q;
      out_data_q <= data_d;
      out_sec_q  <= s1_vld_q && (stat_d == SEC);
      out_ded_q  <= s1_vld_q && (stat_d == DED);
      out_pos_q  <= s1_vld_q ? pos_d : '0;
    end
  end

  always_comb begin
    sec_cnt_d = sec_cnt_q;
    ded_cnt_d = ded_cnt_q;
    if (i_clr_cnt) begin
      sec_cnt_d = '0;
      ded_cnt_d = '0;
    end else if (out_hs) begin
      if (out_sec_q && (sec_cnt_q != '1)) sec_cnt_d = sec_cnt_q + CNT_W'(1);
      if (out_ded_q && (ded_cnt_q != '1)) ded_cnt_d = ded_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sec_cnt_q <= '0;
      ded_cnt_q <= '0;
    end else begin
      sec_cnt_q <= sec_cnt_d;
      ded_cnt_q <= ded_cnt_d;
    end
  end

  assign o_valid   = out_vld_q;
  assign o_data    = out_data_q;
  assign o_sec     = out_sec_q;
  assign o_ded     = out_ded_q;
  assign o_err_pos = out_pos_q;
  assign o_sec_cnt = sec_cnt_q;
  assign o_ded_cnt = ded_cnt_q;

endmodule

// File: tb/tb_ham_dec_pipe.sv
// Bench for ham_dec_pipe (DATA_BITS=8, CNT_W=4): known vectors, stall stream,
// random error injection, counter saturation/clear and mid-stream reset.
module tb_ham_dec_pipe;

  localparam int EW = 12;
  localparam int CW = 4;

  logic            i_clk = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [EW+1:1]   i_code = '0;
  logic            i_valid = 1'b0;
  logic            o_ready;
  logic [7:0]      o_data;
  logic            o_valid;
  logic            i_ready = 1'b1;
  logic            o_sec;
  logic            o_ded;
  logic [3:0]      o_err_pos;
  logic            i_clr_cnt = 1'b0;
  logic [CW-1:0]   o_sec_cnt;
  logic [CW-1:0]   o_ded_cnt;

  typedef struct {
    logic [13:1] code;
    logic [7:0]  data;
    logic        sec;
    logic        ded;
    logic [3:0]  pos;
  } vec_t;

  vec_t        tbl[8];
  logic [13:0] exp_q[$];
  int          nvec = 0;
  int          nfail = 0;
  int          m_sec = 0;
  int          m_ded = 0;
  logic        arm_clr = 1'b0;
  int          rdy_mode = 0;
  int          cyc = 0;
  int          stall_lo = 0;
  int          stall_hi = 0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_out = '0;

  ham_dec_pipe #(.DATA_BITS(8), .CNT_W(CW)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_code   (i_code),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .o_data   (o_data),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sec    (o_sec),
    .o_ded    (o_ded),
    .o_err_pos(o_err_pos),
    .i_clr_cnt(i_clr_cnt),
    .o_sec_cnt(o_sec_cnt),
    .o_ded_cnt(o_ded_cnt)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [13:1] enc(input logic [7:0] d);
    logic [13:1] w;
    int k;
    w = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 4; b++) begin
      logic x;
      x = 1'b0;
      for (int p = 1; p <= 12; p++)
        if (((p >> b) & 1) == 1 && p != (1 << b)) x = x ^ w[p];
      w[1 << b] = x;
    end
    w[13] = ^w[12:1];
    return w;
  endfunction

  function automatic logic [7:0] extract(input logic [13:1] w);
    logic [7:0] d;
    int k;
    d = '0;
    k = 0;
    for (int p = 1; p <= 12; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[k] = w[p];
        k++;
      end
    end
    return d;
  endfunction

  function automatic logic [13:0] pk(input logic [7:0] d, input logic s,
                                     input logic dd, input logic [3:0] p);
    return {d, s, dd, p};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  always @(negedge i_clk) begin
    cyc++;
    case (rdy_mode)
      1:       i_ready = ($urandom_range(0, 3) != 0);
      2:       i_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      default: i_ready = 1'b1;
    endcase
  end

  task automatic send(input logic [13:1] c, input logic [13:0] e);
    int n;
    n = 0;
    @(negedge i_clk);
    i_code  = c;
    i_valid = 1'b1;
    #1;
    while (!o_ready && n < 200) begin
      @(negedge i_clk);
      #1;
      n++;
    end
    if (o_ready) exp_q.push_back(e);
    else begin
      nvec++;
      nfail++;
      $display("FAIL send_timeout: got o_ready=0 expected 1");
    end
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge i_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      nvec++;
      nfail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge i_clk);
    #1;
  endtask

  task automatic send_rand(input int nerr_max, input bit force_sec);
    logic [7:0]  d;
    logic [13:1] w;
    int          n, e1, e2;
    d  = 8'($urandom_range(0, 255));
    w  = enc(d);
    n  = force_sec ? 1 : $urandom_range(0, nerr_max);
    e1 = $urandom_range(1, 13);
    e2 = $urandom_range(1, 13);
    while (e2 == e1) e2 = $urandom_range(1, 13);
    if (n >= 1) w[e1] = ~w[e1];
    if (n == 2) w[e2] = ~w[e2];
    if (n == 0)      send(w, pk(d, 1'b0, 1'b0, 4'd0));
    else if (n == 1) send(w, pk(d, 1'b1, 1'b0, 4'(e1)));
    else             send(w, pk(extract(w), 1'b0, 1'b1, 4'd0));
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge i_clk) begin
    logic [13:0] cur;
    logic [13:0] e;
    #1;
    i_clr_cnt = 1'b0;
    if (!i_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      cur = {o_data, o_sec, o_ded, o_err_pos};
      if (prev_stall) begin
        chk("stall_hold", 32'(cur), 32'(prev_out));
        chk("stall_valid", 32'(o_valid), 32'd1);
      end
      chk("sec_cnt", 32'(o_sec_cnt), 32'(m_sec));
      chk("ded_cnt", 32'(o_ded_cnt), 32'(m_ded));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_out: got %0h expected none", cur);
        end else begin
          e = exp_q.pop_front();
          chk("out_beat", 32'(cur), 32'(e));
        end
        if (arm_clr && o_sec) begin
          i_clr_cnt = 1'b1;
          arm_clr   = 1'b0;
        end
      end
      if (i_clr_cnt) begin
        m_sec = 0;
        m_ded = 0;
      end else if (o_valid && i_ready) begin
        if (o_sec && m_sec < 15) m_sec++;
        if (o_ded && m_ded < 15) m_ded++;
      end
      prev_stall = o_valid && !i_ready;
      prev_out   = cur;
    end
  end

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{13'h0A27, 8'hA5, 1'b0, 1'b0, 4'd0};
    tbl[1] = '{13'h0A07, 8'hA5, 1'b1, 1'b0, 4'd6};
    tbl[2] = '{13'h1A27, 8'hA5, 1'b1, 1'b0, 4'd13};
    tbl[3] = '{13'h0A33, 8'hA6, 1'b0, 1'b1, 4'd0};
    tbl[4] = '{13'h0089, 8'h00, 1'b0, 1'b1, 4'd0};
    tbl[5] = '{13'h0000, 8'h00, 1'b0, 1'b0, 4'd0};
    tbl[6] = '{13'h0A26, 8'hA5, 1'b1, 1'b0, 4'd1};
    tbl[7] = '{13'h0227, 8'hA5, 1'b1, 1'b0, 4'd12};

    // reset state
    repeat (2) @(negedge i_clk);
    #1;
    chk("rst_valid", 32'(o_valid), 32'd0);
    chk("rst_data", 32'(o_data), 32'd0);
    chk("rst_flags", 32'({o_sec, o_ded}), 32'd0);
    chk("rst_pos", 32'(o_err_pos), 32'd0);
    chk("rst_cnts", 32'({o_sec_cnt, o_ded_cnt}), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(o_ready), 32'd1);

    // accept-to-valid latency of a clean word
    @(negedge i_clk);
    i_code  = 13'h0A27;
    i_valid = 1'b1;
    #1;
    chk("lat_ready", 32'(o_ready), 32'd1);
    exp_q.push_back(pk(8'hA5, 1'b0, 1'b0, 4'd0));
    @(negedge i_clk);
    i_valid = 1'b0;
    #1;
    chk("lat_cycle1", 32'(o_valid), 32'd0);
    @(negedge i_clk);
    #1;
    chk("lat_cycle2", 32'(o_valid), 32'd1);
    drain();

    // known vectors
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].code, pk(tbl[i].data, tbl[i].sec, tbl[i].ded, tbl[i].pos));
      idle();
      drain();
    end
    chk("tbl_sec_cnt", 32'(o_sec_cnt), 32'd4);
    chk("tbl_ded_cnt", 32'(o_ded_cnt), 32'd2);

    // back-to-back stream with a downstream stall window
    rdy_mode = 2;
    stall_lo = cyc + 3;
    stall_hi = cyc + 6;
    for (int i = 0; i < 8; i++) send_rand(1, 1'b0);
    idle();
    drain();
    rdy_mode = 0;

    // random stimulus with random backpressure and input gaps
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      send_rand(2, 1'b0);
      if ($urandom_range(0, 3) == 0) idle();
    end
    idle();
    drain();
    rdy_mode = 0;

    // saturation of the 4-bit counter
    for (int i = 0; i < 20; i++) send_rand(0, 1'b1);
    idle();
    drain();
    chk("sat_sec_cnt", 32'(o_sec_cnt), 32'd15);

    // clear coincident with a counted sec beat
    arm_clr = 1'b1;
    send_rand(0, 1'b1);
    idle();
    drain();
    chk("clr_sec_cnt", 32'(o_sec_cnt), 32'd0);
    chk("clr_ded_cnt", 32'(o_ded_cnt), 32'd0);

    // reset in the middle of a stream
    for (int i = 0; i < 4; i++) send_rand(0, 1'b1);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b0;
    exp_q.delete();
    m_sec = 0;
    m_ded = 0;
    #1;
    chk("midrst_valid", 32'(o_valid), 32'd0);
    chk("midrst_sec_cnt", 32'(o_sec_cnt), 32'd0);
    chk("midrst_ded_cnt", 32'(o_ded_cnt), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("midrst_rel_valid", 32'(o_valid), 32'd0);
    chk("midrst_rel_ready", 32'(o_ready), 32'd1);
    send(13'h0A27, pk(8'hA5, 1'b0, 1'b0, 4'd0));
    idle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
